soc_system_pio_hs_out: RTL and testbench
========================================

# soc_system_pio_hs_out

Avalon-MM slave output PIO that drives a 32-bit word from the HPS/Qsys bus into FPGA fabric with a valid/ack handshake. It is the write-direction companion to the edge-capturing input PIOs on the same lightweight bridge. Software writes data, bit-set or bit-clear words, and the block forwards each resulting value to fabric as one handshaken transfer. Status bits report pending data, coalesced writes and ack timeouts.

## Interface
- DATA_WIDTH, 32, width of the data registers and `out_port`; must be 1..32, and unused `readdata` bits read 0.
- RESET_VALUE, 0, reset value of `out_port` and of the target register.
- TIMEOUT_CYCLES, 1024, number of cycles `out_valid` may wait for `out_ack` before the transfer is aborted; must be 2..65535.
- clk, in, 1, clock.
- reset_n, in, 1, reset: asynchronous, active-low.
- address, in, 2, register select.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe; a write is `chipselect && !write_n`.
- writedata, in, 32, write data.
- readdata, out, 32, registered read data.
- out_port, out, DATA_WIDTH, value presented to fabric.
- out_valid, out, 1, `out_port` holds a new value.
- out_ack, in, 1, fabric accepts the value; synchronous to `clk`.

## Operation
- Registers:
  - 0 DATA: a write sets target = writedata. A read returns target.
  - 1 STATUS: read returns bit0 busy (`out_valid`), bit1 pending, bit2 overflow, bit3 timeout. Writing 1 to bit2 or bit3 clears that flag; writing 0 has no effect.
  - 2 OUTSET: a write sets target = target | writedata.
  - 3 OUTCLEAR: a write sets target = target & ~writedata.
- Each write to address 0, 2 or 3 sets pending. Writes to STATUS never set pending.
- Overflow is set when a write that sets pending arrives while pending is already 1 and is not being consumed at that edge. The writes coalesce and the last result wins.
- FSM IDLE:
  - If pending: `out_port` <= target (the value before any same-edge write), `out_valid` <= 1, clear pending, reset the timeout counter, go to SEND.
  - A write on that same edge sets pending again without flagging overflow.
- FSM SEND:
  - If `out_ack` is 1: `out_valid` <= 0, go to IDLE.
  - Else if the counter reaches TIMEOUT_CYCLES-1: `out_valid` <= 0, set timeout, go to IDLE. `out_port` keeps its value.
  - Else increment the counter.
- `out_ack` is ignored in IDLE.
- `out_port` changes only on a load. It is stable for the whole time `out_valid` is 1.
- When no load occurs on an edge, the target write and the pending set from a register write both take effect.
- `readdata` is registered every cycle from the address mux; `chipselect` is not required for reads.
- Reset (asynchronous, at any time, including mid-transfer):
  - `out_port` = RESET_VALUE, target = RESET_VALUE.
  - `out_valid`, pending, overflow, timeout, counter and `readdata` = 0; FSM to IDLE.
  - No transfer resumes after reset.

## Timing
- A write sampled at edge N updates target and pending at N. The load happens at N+1, so `out_valid` is high from N+1.
- `out_ack` high at edge M with `out_valid` high: `out_valid` is low after M. The transfer lasts at least 1 cycle.
- When pending is set, the next load is at M+1. `out_valid` is therefore low for at least one cycle between transfers, so back-to-back transfers are 2 cycles apart.
- Timeout: with `out_ack` held low, `out_valid` is high for exactly TIMEOUT_CYCLES cycles.
- Read latency is 1 cycle: address sampled at N, `readdata` valid after N.
- STATUS bits reflect register state as of the sampling edge.

## Test plan
- Reset, then read all four addresses: `readdata` = RESET_VALUE, 0, RESET_VALUE, RESET_VALUE; `out_valid` = 0.
- Write DATA = 0x0000_00F0, then OUTSET 0x0F, then OUTCLEAR 0x30, with `out_ack` tied high:
  - Three transfers of 0xF0, 0xFF, 0xCF, each starting one cycle after its write (the OUTSET and OUTCLEAR writes are spaced at least 2 cycles apart).
  - Overflow stays 0.
- Hold `out_ack` = 0, write 0x11, then 0x22 and 0x33 during the stall:
  - Overflow = 1, and STATUS reads 0x7 (busy, pending, overflow).
  - Raise `out_ack` for one cycle: the first transfer is 0x11, `out_valid` drops, and after a 1-cycle gap 0x33 is sent; 0x22 is never presented.
- TIMEOUT_CYCLES = 8, `out_ack` = 0, write 0xA5:
  - `out_valid` is high for exactly 8 cycles, then STATUS bit3 = 1 and `out_port` stays 0xA5.
  - Write STATUS 0x8: bit3 reads 0.
- Assert reset_n low during the SEND state while `out_valid` is high and pending is set: asynchronously `out_valid` = 0 and `out_port` = RESET_VALUE. After release, no transfer occurs until the next write.
- In IDLE with pending = 1, a write of 0x55 on the load edge: the old target is sent, 0x55 is sent next, and overflow stays 0.

Source files
------------

// File: rtl/soc_system_pio_hs_out.sv
// soc_system_pio_hs_out: Avalon-MM output PIO forwarding each written word to fabric over a valid/ack handshake
// Ports: clk, reset_n (async active-low); address/chipselect/write_n/writedata/readdata form the
//        Avalon slave (0 DATA, 1 STATUS, 2 OUTSET, 3 OUTCLEAR); out_port/out_valid/out_ack form the
//        fabric handshake.
module soc_system_pio_hs_out #(
   parameter int                    DATA_WIDTH     = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE    = '0,
   parameter int                    TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port,
   output logic                  out_valid,
   input  logic                  out_ack
);
   typedef enum logic {IDLE, SEND} state_t;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] target_q, target_d, port_q, port_d, wdata;
   logic                  pending_q, pending_d, overflow_q, overflow_d, timeout_q, timeout_d;
   logic [15:0]           cnt_q, cnt_d;
   logic [31:0]           readdata_q, readdata_d;
   logic                  wr, wr_tgt, wr_stat, load, expire;
   always_comb begin
      wr         = chipselect && !write_n;
      wr_tgt     = wr && address != 2'd1;
      wr_stat    = wr && address == 2'd1;
      wdata      = writedata[DATA_WIDTH-1:0];
      load       = state_q == IDLE && pending_q;
      expire     = state_q == SEND && !out_ack && cnt_q == 16'(TIMEOUT_CYCLES - 1);
      state_d    = state_q;
      port_d     = port_q;
      cnt_d      = cnt_q;
      // the load sends the pre-write target; a write on the load edge simply re-arms pending
      target_d   = !wr_tgt ? target_q :
                   address == 2'd0 ? wdata :
                   address == 2'd2 ? target_q | wdata : target_q & ~wdata;
      pending_d  = wr_tgt || (pending_q && !load);
      overflow_d = (wr_tgt && pending_q && !load) || (overflow_q && !(wr_stat && writedata[2]));
      timeout_d  = expire || (timeout_q && !(wr_stat && writedata[3]));
      if (load) begin
         state_d = SEND;
         port_d  = target_q;
         cnt_d   = '0;
      end else if (state_q == SEND) begin
         if (out_ack || expire) state_d = IDLE;
         else cnt_d = cnt_q + 16'd1;
      end
      readdata_d = address == 2'd1 ? {28'd0, timeout_q, overflow_q, pending_q, state_q == SEND}
                                   : 32'(target_q);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         target_q   <= RESET_VALUE;
         port_q     <= RESET_VALUE;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         cnt_q      <= '0;
         readdata_q <= '0;
      end else begin
         state_q    <= state_d;
         target_q   <= target_d;
         port_q     <= port_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
         cnt_q      <= cnt_d;
         readdata_q <= readdata_d;
      end
   end
   assign out_valid = state_q == SEND;
   assign out_port  = port_q;
   assign readdata  = readdata_q;
endmodule

// File: tb/tb_soc_system_pio_hs_out.sv
// tb_soc_system_pio_hs_out: directed and randomized checks of the handshaken output PIO
module tb_soc_system_pio_hs_out;
   localparam int          T  = 8;
   localparam logic [31:0] RV = 32'h1234_5678;
   logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1, out_ack = 0, out_valid;
   logic [1:0]  address = 0;
   logic [31:0] writedata = 0, readdata, out_port;
   int          checks = 0, errors = 0;
   logic [31:0] m_tgt, m_port, m_rd;
   bit          m_pend, m_ovf, m_to, m_busy;
   int          m_wait;
   logic [31:0] exp_q[$], obs_q[$];
   logic        pv = 0;
   always #5 clk = ~clk;
   soc_system_pio_hs_out #(.DATA_WIDTH(32), .RESET_VALUE(RV), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
      .writedata(writedata), .readdata(readdata), .out_port(out_port), .out_valid(out_valid),
      .out_ack(out_ack));
   always @(negedge clk) begin
      if (out_valid && !pv) obs_q.push_back(out_port);
      pv <= out_valid;
   end
   task automatic model_reset();
      m_tgt = RV; m_port = RV; m_rd = 0;
      m_pend = 0; m_ovf = 0; m_to = 0; m_busy = 0; m_wait = 0;
   endtask
   task automatic model_step();
      bit w, wt, ld;
      logic [31:0] nv;
      if (!reset_n) begin
         model_reset();
         return;
      end
      w    = chipselect && !write_n;
      wt   = w && address != 2'd1;
      m_rd = address == 2'd1 ? {28'd0, m_to, m_ovf, m_pend, m_busy} : m_tgt;
      nv   = address == 2'd0 ? writedata : address == 2'd2 ? (m_tgt | writedata) : (m_tgt & ~writedata);
      ld   = !m_busy && m_pend;
      if (w && address == 2'd1 && writedata[2]) m_ovf = 0;
      if (w && address == 2'd1 && writedata[3]) m_to = 0;
      if (ld) begin
         m_port = m_tgt; m_busy = 1; m_wait = 0;
         exp_q.push_back(m_tgt);
      end else if (m_busy) begin
         if (out_ack) m_busy = 0;
         else if (m_wait == T - 1) begin m_busy = 0; m_to = 1; end
         else m_wait++;
      end
      if (wt && m_pend && !ld) m_ovf = 1;
      m_pend = wt || (m_pend && !ld);
      if (wt) m_tgt = nv;
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1; write_n = 0;
      tick();
      chipselect = 0; write_n = 1;
   endtask
   task automatic test_reset();
      logic [31:0] e;
      reset_n = 0;
      repeat (3) tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_port !== RV) begin errors++; $display("FAIL reset_port: got %h want %h", out_port, RV); end
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h want 0", readdata); end
      @(posedge clk); #1;
      reset_n = 1;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         tick();
         @(negedge clk);
         e = a == 1 ? 32'd0 : RV;
         checks++; if (readdata !== e) begin errors++; $display("FAIL reset_read[%0d]: got %h want %h", a, readdata, e); end
      end
   endtask
   task automatic test_set_clear();
      logic [1:0]  ad[3] = '{2'd0, 2'd2, 2'd3};
      logic [31:0] dt[3] = '{32'hF0, 32'h0F, 32'h30};
      logic [31:0] ev[3] = '{32'hF0, 32'hFF, 32'hCF};
      out_ack = 1;
      for (int i = 0; i < 3; i++) begin
         wr(ad[i], dt[i]);
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setclr_prewait[%0d]: got %b want 0", i, out_valid); end
         tick();
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_port !== ev[i]) begin errors++; $display("FAIL setclr_xfer[%0d]: got valid %b port %h want 1 %h", i, out_valid, out_port, ev[i]); end
         tick();
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setclr_drop[%0d]: got %b want 0", i, out_valid); end
      end
      address = 1;
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL setclr_status: got %h want 0", readdata); end
      out_ack = 0;
   endtask
   task automatic test_coalesce();
      int seen;
      out_ack = 0;
      wr(0, 32'h11);
      tick();
      wr(0, 32'h22);
      wr(0, 32'h33);
      address = 1;
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'h7) begin errors++; $display("FAIL coalesce_status: got %h want 7", readdata); end
      checks++; if (out_valid !== 1'b1 || out_port !== 32'h11) begin errors++; $display("FAIL coalesce_first: got %b %h want 1 11", out_valid, out_port); end
      out_ack = 1;
      tick();
      out_ack = 0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || out_port !== 32'h11) begin errors++; $display("FAIL coalesce_gap: got %b %h want 0 11", out_valid, out_port); end
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_port !== 32'h33) begin errors++; $display("FAIL coalesce_last: got %b %h want 1 33", out_valid, out_port); end
      out_ack = 1;
      tick();
      out_ack = 0;
      wr(1, 32'h4);
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL coalesce_ovf_clear: got %h want 0", readdata); end
      seen = 0;
      foreach (obs_q[i]) if (obs_q[i] == 32'h22) seen++;
      checks++; if (seen != 0) begin errors++; $display("FAIL coalesce_skipped: got %0d presentations of 22 want 0", seen); end
   endtask
   task automatic test_timeout();
      int n = 0;
      out_ack = 0;
      wr(0, 32'hA5);
      for (int i = 0; i < 20; i++) begin
         tick();
         @(negedge clk);
         if (out_valid) n++;
      end
      checks++; if (n != T) begin errors++; $display("FAIL timeout_len: got %0d want %0d", n, T); end
      checks++; if (out_port !== 32'hA5) begin errors++; $display("FAIL timeout_port: got %h want a5", out_port); end
      address = 1;
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'h8) begin errors++; $display("FAIL timeout_status: got %h want 8", readdata); end
      wr(1, 32'h8);
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL timeout_clear: got %h want 0", readdata); end
   endtask
   task automatic test_reset_mid();
      int n = 0;
      out_ack = 0;
      wr(0, 32'h77);
      tick();
      wr(0, 32'h88);
      #2;
      reset_n = 0;
      model_reset();
      #1;
      checks++; if (out_valid !== 1'b0 || out_port !== RV) begin errors++; $display("FAIL resetmid_async: got %b %h want 0 %h", out_valid, out_port, RV); end
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL resetmid_readdata: got %h want 0", readdata); end
      tick();
      tick();
      reset_n = 1;
      address = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         @(negedge clk);
         if (out_valid) n++;
      end
      checks++; if (n != 0) begin errors++; $display("FAIL resetmid_noresume: got %0d valid cycles want 0", n); end
      checks++; if (readdata !== RV) begin errors++; $display("FAIL resetmid_target: got %h want %h", readdata, RV); end
      wr(0, 32'h99);
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_port !== 32'h99) begin errors++; $display("FAIL resetmid_next: got %b %h want 1 99", out_valid, out_port); end
      out_ack = 1;
      tick();
      out_ack = 0;
   endtask
   task automatic test_load_edge();
      out_ack = 1;
      wr(0, 32'h44);
      wr(0, 32'h55);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_port !== 32'h44) begin errors++; $display("FAIL loadedge_old: got %b %h want 1 44", out_valid, out_port); end
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL loadedge_gap: got %b want 0", out_valid); end
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_port !== 32'h55) begin errors++; $display("FAIL loadedge_new: got %b %h want 1 55", out_valid, out_port); end
      address = 1;
      tick();
      tick();
      @(negedge clk);
      checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL loadedge_status: got %h want 0", readdata); end
      out_ack = 0;
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         address    = 2'($urandom_range(0, 3));
         chipselect = $urandom_range(0, 3) != 0;
         write_n    = $urandom_range(0, 2) != 0;
         writedata  = $urandom_range(0, 1) ? $urandom : 32'(1) << $urandom_range(0, 7);
         out_ack    = $urandom_range(0, 3) == 0;
         tick();
         @(negedge clk);
         checks++; if (out_valid !== m_busy) begin errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_busy); end
         checks++; if (out_port !== m_port) begin errors++; $display("FAIL rand_port[%0d]: got %h want %h", i, out_port, m_port); end
         checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata[%0d]: got %h want %h", i, readdata, m_rd); end
      end
      chipselect = 0; write_n = 1; out_ack = 1;
      repeat (6) tick();
      out_ack = 0;
      @(negedge clk);
   endtask
   task automatic test_transfers();
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL xfer_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL xfer_value[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); end
      end
   endtask
   initial begin
      test_reset();
      test_set_clear();
      test_coalesce();
      test_timeout();
      test_reset_mid();
      test_load_edge();
      test_random();
      test_transfers();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
